bht_2bit: RTL

BHT_2BIT -- requirements
Module: bht_2bit

---
 rtl/bht_2bit_if.sv | 30 +++
 rtl/bht_2bit.sv | 107 ++++++++++
 2 files changed

// File: rtl/bht_2bit_if.sv
// Fetch-side prediction and EX-side resolution signals of the 2-bit branch history table.
interface bht_2bit_if;
    logic [31:0] fetch_pc;
    logic        T_NT;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_pred;
    logic [31:0] mispredict_cnt;

    modport master (
        output fetch_pc,
        output update_en,
        output update_pc,
        output update_taken,
        output update_pred,
        input  T_NT,
        input  mispredict_cnt
    );

    modport slave (
        input  fetch_pc,
        input  update_en,
        input  update_pc,
        input  update_taken,
        input  update_pred,
        output T_NT,
        output mispredict_cnt
    );
endinterface

// File: rtl/bht_2bit.sv
// Direct-mapped table of 2-bit saturating branch predictors with a misprediction counter.
// Define BHT_BYPASS_EN to forward a same-cycle, same-index update onto T_NT.
module bht_2bit #(
    parameter int INDEX_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    bht_2bit_if.slave bus
);

    localparam int ENTRIES = 2 ** INDEX_W;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) nxt = ctr;
            else              nxt = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) nxt = ctr;
            else              nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        logic [31:0] nxt;
        if (val == 32'hFFFF_FFFF) nxt = val;
        else                      nxt = val + 32'd1;
        return nxt;
    endfunction

    logic [INDEX_W-1:0] fetch_idx_s;
    logic [INDEX_W-1:0] update_idx_s;
    logic [1:0]         update_ctr_s;
    logic [1:0]         table_q [ENTRIES];
    logic [1:0]         table_d [ENTRIES];
    logic [31:0]        mispredict_cnt_q;
    logic [31:0]        mispredict_cnt_d;
    logic               t_nt_s;
    logic               unused_pc_bits_s;

    assign fetch_idx_s      = bus.fetch_pc[INDEX_W+1:2];
    assign update_idx_s     = bus.update_pc[INDEX_W+1:2];
    assign update_ctr_s     = ctr_next(table_q[update_idx_s], bus.update_taken);
    // Low byte-offset bits and tag bits above the index never select an entry.
    assign unused_pc_bits_s = ^{bus.fetch_pc[1:0], bus.fetch_pc[31:INDEX_W+2],
                                bus.update_pc[1:0], bus.update_pc[31:INDEX_W+2]};

    // Next table contents: only the addressed entry moves, and only on an update strobe.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (bus.update_en) begin
            table_d[update_idx_s] = update_ctr_s;
        end else begin
            table_d[update_idx_s] = table_q[update_idx_s];
        end
    end

    // Next misprediction count, saturating at all-ones.
    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        if (bus.update_en && (bus.update_pred != bus.update_taken)) begin
            mispredict_cnt_d = sat_inc32(mispredict_cnt_q);
        end else begin
            mispredict_cnt_d = mispredict_cnt_q;
        end
    end

    // Zero-latency prediction for the fetch PC; suppressed while in reset.
    always_comb begin
        t_nt_s = 1'b0;
        if (rst) begin
            t_nt_s = 1'b0;
        end else begin
`ifdef BHT_BYPASS_EN
            if (bus.update_en && (update_idx_s == fetch_idx_s)) begin
                t_nt_s = update_ctr_s[1];
            end else begin
                t_nt_s = table_q[fetch_idx_s][1];
            end
`else
            t_nt_s = table_q[fetch_idx_s][1];
`endif
        end
    end

    // State registers; reset overrides any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            mispredict_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.T_NT           = t_nt_s;
    assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
